// File: rtl/fsm_code_lock_param.sv
// rtl/fsm_code_lock_param.sv - parametrised bit-serial combination lock with timed open window and alarm lockout
//
// Ports:
//   CLK      in   rising-edge clock
//   R_N      in   asynchronous active-low reset
//   IN       in   code bit, taken when VALID=1
//   VALID    in   bit strobe, one bit per VALID cycle
//   CLR      in   abort partial entry / relock early
//   Unlock   out  door open window (registered)
//   Alarm    out  lockout active (registered)
//   Fail     out  one-cycle pulse per wrong code (registered)
//   FailCnt  out  consecutive wrong codes
//   State    out  00 ENTRY, 01 OPEN, 10 LOCKOUT
module fsm_code_lock_param #(
    parameter int                  CODE_LEN    = 4,
    parameter logic [CODE_LEN-1:0] CODE        = 4'b1011,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  UNLOCK_CYC  = 4,
    parameter int                  LOCKOUT_CYC = 8,
    localparam int                 FC_W        = $clog2(MAX_FAIL + 1)
) (
    input  logic            CLK,
    input  logic            R_N,
    input  logic            IN,
    input  logic            VALID,
    input  logic            CLR,
    output logic            Unlock,
    output logic            Alarm,
    output logic            Fail,
    output logic [FC_W-1:0] FailCnt,
    output logic [1:0]      State
);

    localparam int CNT_W = $clog2(CODE_LEN);
    localparam int T_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int TMR_W = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  MAX_FC       = FC_W'(MAX_FAIL);
    // The edge that loads the timer already starts the first high cycle,
    // so the load value is one less than the window length.
    localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYC - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'b00,
        ST_OPEN    = 2'b01,
        ST_LOCKOUT = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_LEN-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [FC_W-1:0]     fc_q, fc_d;
    logic                unlock_q, unlock_d;
    logic                alarm_q, alarm_d;
    logic                fail_q, fail_d;

    logic [CODE_LEN-1:0] entry_word;
    logic [FC_W-1:0]     fc_inc;

    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            state_q  <= ST_ENTRY;
            sh_q     <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            fc_q     <= '0;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            fc_q     <= fc_d;
            unlock_q <= unlock_d;
            alarm_q  <= alarm_d;
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        fc_d       = fc_q;
        unlock_d   = unlock_q;
        alarm_d    = alarm_q;
        fail_d     = 1'b0;
        // Word as it will look once the current bit is shifted in; the
        // comparison uses it so the decision lands on the last-bit edge.
        entry_word = {sh_q[CODE_LEN-2:0], IN};
        fc_inc     = fc_q + 1'b1;

        case (state_q)
            ST_ENTRY: begin
                if (CLR) begin
                    cnt_d = '0;
                end else if (VALID) begin
                    sh_d = entry_word;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
                        if (entry_word == CODE) begin
                            state_d  = ST_OPEN;
                            unlock_d = 1'b1;
                            timer_d  = UNLOCK_LOAD;
                            fc_d     = '0;
                        end else begin
                            fail_d = 1'b1;
                            fc_d   = fc_inc;
                            if (fc_inc == MAX_FC) begin
                                state_d = ST_LOCKOUT;
                                alarm_d = 1'b1;
                                timer_d = LOCKOUT_LOAD;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_OPEN: begin
                if (CLR || (timer_q == '0)) begin
                    state_d  = ST_ENTRY;
                    unlock_d = 1'b0;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = ST_ENTRY;
                    alarm_d = 1'b0;
                    fc_d    = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d  = ST_ENTRY;
                unlock_d = 1'b0;
                alarm_d  = 1'b0;
                timer_d  = '0;
                cnt_d    = '0;
            end
        endcase
    end

    assign Unlock  = unlock_q;
    assign Alarm   = alarm_q;
    assign Fail    = fail_q;
    assign FailCnt = fc_q;
    assign State   = state_q;

endmodule

// File: tb/tb_fsm_code_lock_param.sv
// tb/tb_fsm_code_lock_param.sv - randomized self-checking bench for fsm_code_lock_param
module tb_fsm_code_lock_param;

    localparam int         CODE_LEN    = 4;
    localparam logic [3:0] TB_CODE     = 4'b1011;
    localparam int         MAX_FAIL    = 3;
    localparam int         UNLOCK_CYC  = 4;
    localparam int         LOCKOUT_CYC = 8;
    localparam int         FC_W        = $clog2(MAX_FAIL + 1);

    logic            CLK = 1'b0;
    logic            R_N;
    logic            IN;
    logic            VALID;
    logic            CLR;
    logic            Unlock;
    logic            Alarm;
    logic            Fail;
    logic [FC_W-1:0] FailCnt;
    logic [1:0]      State;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bits typed so far, cycles left in each timed window.
    bit q_bits[$];
    int open_left  = 0;
    int alarm_left = 0;
    int fails      = 0;
    bit exp_fail   = 0;

    fsm_code_lock_param #(
        .CODE_LEN   (CODE_LEN),
        .CODE       (TB_CODE),
        .MAX_FAIL   (MAX_FAIL),
        .UNLOCK_CYC (UNLOCK_CYC),
        .LOCKOUT_CYC(LOCKOUT_CYC)
    ) dut (
        .CLK    (CLK),
        .R_N    (R_N),
        .IN     (IN),
        .VALID  (VALID),
        .CLR    (CLR),
        .Unlock (Unlock),
        .Alarm  (Alarm),
        .Fail   (Fail),
        .FailCnt(FailCnt),
        .State  (State)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q_bits.delete();
        open_left  = 0;
        alarm_left = 0;
        fails      = 0;
        exp_fail   = 0;
    endfunction

    function automatic void model_edge(bit v, bit b, bit c);
        bit idle;
        idle     = (open_left == 0) && (alarm_left == 0);
        exp_fail = 0;
        if (open_left > 0) begin
            if (c) open_left = 0;
            else   open_left--;
        end else if (alarm_left > 0) begin
            alarm_left--;
            if (alarm_left == 0) fails = 0;
        end
        if (idle) begin
            if (c) begin
                q_bits.delete();
            end else if (v) begin
                q_bits.push_back(b);
                if (q_bits.size() == CODE_LEN) begin
                    int val;
                    val = 0;
                    foreach (q_bits[i]) val = val * 2 + int'(q_bits[i]);
                    q_bits.delete();
                    if (val == int'(TB_CODE)) begin
                        open_left = UNLOCK_CYC;
                        fails     = 0;
                    end else begin
                        exp_fail = 1;
                        fails++;
                        if (fails == MAX_FAIL) alarm_left = LOCKOUT_CYC;
                    end
                end
            end
        end
    endfunction

    task automatic check_outputs();
        int exp_state;
        exp_state = (open_left > 0) ? 1 : ((alarm_left > 0) ? 2 : 0);
        check("unlock",  32'(Unlock),  32'(open_left > 0));
        check("alarm",   32'(Alarm),   32'(alarm_left > 0));
        check("fail",    32'(Fail),    32'(exp_fail));
        check("failcnt", 32'(FailCnt), 32'(fails));
        check("state",   32'(State),   32'(exp_state));
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        VALID = v;
        IN    = b;
        CLR   = c;
        @(posedge CLK);
        model_edge(v, b, c);
        #1;
        check_outputs();
    endtask

    task automatic send_code(input logic [3:0] code, input bit gaps);
        logic [3:0] w;
        w = code;
        for (int i = 3; i >= 0; i--) begin
            if (gaps && ($urandom_range(0, 3) == 0)) step(1'b0, 1'($urandom), 1'b0);
            step(1'b1, w[i], 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0);
    endtask

    // Reset asserted between clock edges; outputs must clear with no edge.
    task automatic async_reset();
        #2;
        R_N = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2;
        R_N = 1'b1;
    endtask

    initial begin
        R_N   = 1'b0;
        IN    = 1'b0;
        VALID = 1'b0;
        CLR   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        check_outputs();
        #2;
        R_N = 1'b1;

        // Correct code, then let the window expire.
        send_code(4'b1011, 1'b0);
        idle(6);
        // Wrong then right.
        send_code(4'b1001, 1'b0);
        send_code(4'b1011, 1'b0);
        idle(5);
        // Three wrong -> lockout; correct code during lockout is ignored.
        send_code(4'b0000, 1'b0);
        send_code(4'b1111, 1'b0);
        send_code(4'b1010, 1'b0);
        send_code(4'b1011, 1'b0);
        idle(5);
        send_code(4'b1011, 1'b0);
        idle(5);
        // CLR after partial entry, then CLR together with VALID.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        send_code(4'b1011, 1'b0);
        idle(5);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        send_code(4'b1011, 1'b0);
        // CLR in the middle of the open window.
        step(1'b0, 1'b0, 1'b1);
        idle(3);
        // Reset during lockout.
        send_code(4'b0001, 1'b0);
        send_code(4'b0010, 1'b0);
        send_code(4'b0100, 1'b0);
        idle(2);
        async_reset();
        send_code(4'b1011, 1'b0);
        idle(5);

        // Randomized mix.
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r < 12) begin
                send_code(TB_CODE, 1'b1);
            end else if (r < 26) begin
                send_code(4'($urandom), 1'b1);
            end else if (r < 30) begin
                step(1'($urandom), 1'($urandom), 1'b1);
            end else if (r < 38) begin
                step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0));
            end else if (r < 39) begin
                idle($urandom_range(1, 6));
            end else begin
                async_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
